// File: rtl/sdl_pkg.sv
// Shared definitions for the downlink SDL frame scheduler: source codes and FSM encoding.
package sdl_pkg;

    localparam logic [1:0] SrcBsn     = 2'd0;
    localparam logic [1:0] SrcBb      = 2'd1;
    localparam logic [1:0] SrcCircuit = 2'd2;
    localparam logic [1:0] SrcCtrl    = 2'd3;

    localparam int unsigned NumSrc  = 4;
    localparam int unsigned NumWrr  = 3;
    localparam int unsigned CreditW = 4;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    // Round-robin successor over the three weighted sources.
    function automatic logic [1:0] rr_next(input logic [1:0] s);
        return (s == SrcCircuit) ? SrcBsn : s + 2'd1;
    endfunction

endpackage

// File: rtl/sdl_frame_scheduler_if.sv
// Handshake bundle between the frame buffers / SDL reader and the frame scheduler.
interface sdl_frame_scheduler_if #(
    parameter int unsigned CNT_W = 8
);
    logic [3:0]         src_frame_done;
    logic               rd_done;
    logic               err_clr;
    logic               grant_vld;
    logic [1:0]         grant_src;
    logic [3:0]         grant_onehot;
    logic [4*CNT_W-1:0] pending_cnt;
    logic [3:0]         ovf_err;
    logic               timeout_err;

    modport master (
        output src_frame_done, rd_done, err_clr,
        input  grant_vld, grant_src, grant_onehot, pending_cnt, ovf_err, timeout_err
    );

    modport slave (
        input  src_frame_done, rd_done, err_clr,
        output grant_vld, grant_src, grant_onehot, pending_cnt, ovf_err, timeout_err
    );
endinterface

// File: rtl/sdl_wrr_pick.sv
// Combinational credit/pointer selection among BSN, BB and circuit.
module sdl_wrr_pick
    import sdl_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [2:0] i_credit_ok,
    input  logic [1:0] i_rr_ptr,
    output logic [1:0] o_winner,
    output logic       o_winner_vld,
    output logic       o_reload
);

    logic       w_reload;
    logic [2:0] w_elig;
    logic [1:0] w_idx;

    always_comb begin
        // Requests exist but every requester is out of credit: search as if credits reloaded.
        w_reload     = (|i_req) && !(|(i_req & i_credit_ok));
        w_elig       = w_reload ? i_req : (i_req & i_credit_ok);
        o_winner     = i_rr_ptr;
        o_winner_vld = 1'b0;
        w_idx        = i_rr_ptr;
        for (int k = 0; k < NumWrr; k++) begin
            if (!o_winner_vld && w_elig[w_idx]) begin
                o_winner     = w_idx;
                o_winner_vld = 1'b1;
            end
            w_idx = rr_next(w_idx);
        end
        o_reload = w_reload;
    end

endmodule

// File: rtl/sdl_frame_scheduler.sv
// Downlink SDL frame scheduler: per-source pending counts, strict-priority ctrl,
// weighted round-robin for BSN/BB/circuit, one grant per frame with a watchdog.
module sdl_frame_scheduler
    import sdl_pkg::*;
#(
    parameter int unsigned W_BSN     = 4,
    parameter int unsigned W_BB      = 2,
    parameter int unsigned W_CIRCUIT = 1,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 4096
) (
    input logic                 sys_clk,
    input logic                 rst_n,
    sdl_frame_scheduler_if.slave bus
);

    localparam int unsigned WaitW = $clog2(TIMEOUT);

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt [NumSrc];
    logic [CNT_W-1:0]    w_cnt_d [NumSrc];
    logic [CreditW-1:0]  r_credit [NumWrr];
    logic [CreditW-1:0]  w_credit_d [NumWrr];
    logic [1:0]          r_rr_ptr, w_ptr_d;
    logic [1:0]          r_grant_src;
    logic [WaitW-1:0]    r_wait;
    logic [3:0]          r_ovf;
    logic                r_tout;

    logic [3:0]          w_req;
    logic [3:0]          w_ovf_set;
    logic [1:0]          w_pick_win, w_win;
    logic                w_pick_vld, w_reload;
    logic                w_take, w_wrr, w_close, w_tout_fire;
    logic [4*CNT_W-1:0]  w_pending;

    function automatic logic [CreditW-1:0] weight_of(input logic [1:0] s);
        case (s)
            SrcBsn:     return CreditW'(W_BSN);
            SrcBb:      return CreditW'(W_BB);
            SrcCircuit: return CreditW'(W_CIRCUIT);
            default:    return '0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            w_req[i] = (r_cnt[i] != '0);
        end
    end

    sdl_wrr_pick u_pick (
        .i_req        (w_req[2:0]),
        .i_credit_ok  ({r_credit[2] != '0, r_credit[1] != '0, r_credit[0] != '0}),
        .i_rr_ptr     (r_rr_ptr),
        .o_winner     (w_pick_win),
        .o_winner_vld (w_pick_vld),
        .o_reload     (w_reload)
    );

    always_comb begin
        w_state_d   = r_state;
        w_take      = 1'b0;
        w_wrr       = 1'b0;
        w_close     = 1'b0;
        w_tout_fire = 1'b0;
        w_win       = SrcCtrl;
        case (r_state)
            StIdle: begin
                if (w_req[SrcCtrl]) begin
                    w_take    = 1'b1;
                    w_state_d = StGrant;
                end else if (w_pick_vld) begin
                    w_take    = 1'b1;
                    w_wrr     = 1'b1;
                    w_win     = w_pick_win;
                    w_state_d = StGrant;
                end
            end
            StGrant: begin
                // rd_done takes precedence over a coincident watchdog expiry.
                if (bus.rd_done) begin
                    w_close   = 1'b1;
                    w_state_d = StIdle;
                end else if (r_wait == WaitW'(TIMEOUT - 1)) begin
                    w_close     = 1'b1;
                    w_tout_fire = 1'b1;
                    w_state_d   = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_ptr_d = r_rr_ptr;
        for (int j = 0; j < NumWrr; j++) begin
            w_credit_d[j] = r_credit[j];
        end
        if (w_wrr) begin
            if (w_reload) begin
                for (int j = 0; j < NumWrr; j++) begin
                    w_credit_d[j] = weight_of(2'(j));
                end
            end
            w_credit_d[w_pick_win] = w_credit_d[w_pick_win] - CreditW'(1);
            w_ptr_d = (w_credit_d[w_pick_win] == '0) ? rr_next(w_pick_win) : w_pick_win;
        end
    end

    always_comb begin
        w_ovf_set = '0;
        for (int i = 0; i < NumSrc; i++) begin
            w_cnt_d[i] = r_cnt[i];
            if (bus.src_frame_done[i] && !(w_close && r_grant_src == 2'(i))) begin
                if (r_cnt[i] == '1) begin
                    w_ovf_set[i] = 1'b1;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
                end
            end else if (!bus.src_frame_done[i] && w_close && r_grant_src == 2'(i)
                         && r_cnt[i] != '0) begin
                w_cnt_d[i] = r_cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_rr_ptr    <= SrcBsn;
            r_grant_src <= SrcBsn;
            r_wait      <= '0;
            r_ovf       <= '0;
            r_tout      <= 1'b0;
            for (int i = 0; i < NumSrc; i++) begin
                r_cnt[i] <= '0;
            end
            for (int j = 0; j < NumWrr; j++) begin
                r_credit[j] <= weight_of(2'(j));
            end
        end else begin
            r_state  <= w_state_d;
            r_rr_ptr <= w_ptr_d;
            if (w_take) begin
                r_grant_src <= w_win;
                r_wait      <= '0;
            end else if (r_state == StGrant && !w_close) begin
                r_wait <= r_wait + WaitW'(1);
            end
            r_ovf  <= (r_ovf & ~{4{bus.err_clr}}) | w_ovf_set;
            r_tout <= (r_tout & ~bus.err_clr) | w_tout_fire;
            for (int i = 0; i < NumSrc; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            for (int j = 0; j < NumWrr; j++) begin
                r_credit[j] <= w_credit_d[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            w_pending[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign bus.grant_vld    = (r_state == StGrant);
    assign bus.grant_src    = r_grant_src;
    assign bus.grant_onehot = (r_state == StGrant) ? (4'b0001 << r_grant_src) : 4'b0000;
    assign bus.pending_cnt  = w_pending;
    assign bus.ovf_err      = r_ovf;
    assign bus.timeout_err  = r_tout;

endmodule

// File: tb/tb_sdl_frame_scheduler.sv
// Self-checking bench for sdl_frame_scheduler: default, short-watchdog and narrow-counter builds.
module tb_sdl_frame_scheduler;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   q_exp[$];

    always #5 sys_clk = ~sys_clk;

    sdl_frame_scheduler_if #(.CNT_W(8)) m_if ();
    sdl_frame_scheduler_if #(.CNT_W(8)) t_if ();
    sdl_frame_scheduler_if #(.CNT_W(2)) s_if ();

    sdl_frame_scheduler #(.W_BSN(4), .W_BB(2), .W_CIRCUIT(1), .CNT_W(8), .TIMEOUT(4096)) u_main (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (m_if.slave)
    );

    sdl_frame_scheduler #(.W_BSN(4), .W_BB(2), .W_CIRCUIT(1), .CNT_W(8), .TIMEOUT(16)) u_to (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (t_if.slave)
    );

    sdl_frame_scheduler #(.W_BSN(4), .W_BB(2), .W_CIRCUIT(1), .CNT_W(2), .TIMEOUT(4096)) u_sat (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (s_if.slave)
    );

    task automatic do_reset();
        m_if.src_frame_done = '0; m_if.rd_done = 1'b0; m_if.err_clr = 1'b0;
        t_if.src_frame_done = '0; t_if.rd_done = 1'b0; t_if.err_clr = 1'b0;
        s_if.src_frame_done = '0; s_if.rd_done = 1'b0; s_if.err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // Wait (bounded) for an open grant on the main instance.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            if (m_if.grant_vld === 1'b1) ok = 1'b1;
            else @(negedge sys_clk);
        end
    endtask

    // rd_done sampled on the third edge after the grant rose.
    task automatic finish_grant();
        repeat (2) @(negedge sys_clk);
        m_if.rd_done = 1'b1;
        @(negedge sys_clk);
        m_if.rd_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({m_if.grant_vld, m_if.grant_src, m_if.grant_onehot, m_if.ovf_err, m_if.timeout_err}
            !== 12'd0 || m_if.pending_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld=%b src=%0d oh=%b pend=%h ovf=%b to=%b, all 0 required",
                     m_if.grant_vld, m_if.grant_src, m_if.grant_onehot, m_if.pending_cnt,
                     m_if.ovf_err, m_if.timeout_err);
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        m_if.src_frame_done = 4'b0010;
        @(negedge sys_clk);
        m_if.src_frame_done = 4'b0000;
        n_tests++;
        if (m_if.grant_vld !== 1'b0 || m_if.pending_cnt[8 +: 8] !== 8'd1) begin
            n_fail++;
            $display("FAIL single_latency: vld=%b bb_cnt=%0d, required vld=0 cnt=1",
                     m_if.grant_vld, m_if.pending_cnt[8 +: 8]);
        end
        @(negedge sys_clk);
        n_tests++;
        if (m_if.grant_vld !== 1'b1 || m_if.grant_src !== 2'd1 || m_if.grant_onehot !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_grant: vld=%b src=%0d oh=%b, required 1/1/0010",
                     m_if.grant_vld, m_if.grant_src, m_if.grant_onehot);
        end
        repeat (8) @(negedge sys_clk);
        m_if.rd_done = 1'b1;
        @(negedge sys_clk);
        m_if.rd_done = 1'b0;
        n_tests++;
        if (m_if.grant_vld !== 1'b0 || m_if.pending_cnt[8 +: 8] !== 8'd0
            || m_if.grant_onehot !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_release: vld=%b bb_cnt=%0d oh=%b, required 0/0/0000",
                     m_if.grant_vld, m_if.pending_cnt[8 +: 8], m_if.grant_onehot);
        end
        @(negedge sys_clk);
        n_tests++;
        if (m_if.grant_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: vld=%b, required 0 with nothing pending", m_if.grant_vld);
        end
    endtask

    task automatic test_wrr_order();
        int exp_tab[24] = '{0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1, 1, 2,
                            1, 1, 2, 1, 1, 2, 2, 2, 2, 2};
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            m_if.src_frame_done = 4'b0111;
            q_exp.push_back(exp_tab[i]);
            @(negedge sys_clk);
        end
        m_if.src_frame_done = 4'b0000;
        for (int i = 8; i < 24; i++) q_exp.push_back(exp_tab[i]);
        for (int g = 0; g < 24; g++) begin
            int e;
            wait_grant(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL wrr_wait: no grant %0d within 50 cycles", g);
                q_exp.delete();
                break;
            end
            e = q_exp.pop_front();
            n_tests++;
            if (m_if.grant_src !== 2'(e) || m_if.grant_onehot !== (4'b0001 << e)) begin
                n_fail++;
                $display("FAIL wrr_order[%0d]: src=%0d oh=%b, required src=%0d",
                         g, m_if.grant_src, m_if.grant_onehot, e);
            end
            finish_grant();
            n_tests++;
            if (m_if.grant_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL wrr_gap[%0d]: vld=%b after rd_done, required 0", g, m_if.grant_vld);
            end
        end
        n_tests++;
        if (m_if.pending_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL wrr_drain: pend=%h, required 0", m_if.pending_cnt);
        end
    endtask

    task automatic test_ctrl_preempt();
        bit ok;
        do_reset();
        repeat (5) begin
            m_if.src_frame_done = 4'b0001;
            @(negedge sys_clk);
        end
        m_if.src_frame_done = 4'b1000;
        @(negedge sys_clk);
        m_if.src_frame_done = 4'b0000;
        q_exp.push_back(0); q_exp.push_back(3);
        repeat (4) q_exp.push_back(0);
        for (int g = 0; g < 6; g++) begin
            int e;
            wait_grant(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL ctrl_wait: no grant %0d within 50 cycles", g);
                q_exp.delete();
                break;
            end
            e = q_exp.pop_front();
            n_tests++;
            if (m_if.grant_src !== 2'(e)) begin
                n_fail++;
                $display("FAIL ctrl_order[%0d]: src=%0d, required %0d", g, m_if.grant_src, e);
            end
            finish_grant();
        end
        n_tests++;
        if (m_if.pending_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL ctrl_drain: pend=%h, required 0", m_if.pending_cnt);
        end
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        do_reset();
        t_if.src_frame_done = 4'b0011;
        @(negedge sys_clk);
        t_if.src_frame_done = 4'b0000;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (t_if.grant_vld === 1'b1) ok = 1'b1;
            else @(negedge sys_clk);
        end
        n_tests++;
        if (!ok || t_if.grant_src !== 2'd0) begin
            n_fail++;
            $display("FAIL to_first: ok=%b src=%0d, required grant on source 0", ok, t_if.grant_src);
        end
        repeat (15) @(negedge sys_clk);
        n_tests++;
        if (t_if.grant_vld !== 1'b1 || t_if.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: vld=%b to=%b at edge 15, required 1/0",
                     t_if.grant_vld, t_if.timeout_err);
        end
        @(negedge sys_clk);
        n_tests++;
        if (t_if.grant_vld !== 1'b0 || t_if.timeout_err !== 1'b1
            || t_if.pending_cnt[0 +: 8] !== 8'd0) begin
            n_fail++;
            $display("FAIL to_abort: vld=%b to=%b bsn_cnt=%0d, required 0/1/0",
                     t_if.grant_vld, t_if.timeout_err, t_if.pending_cnt[0 +: 8]);
        end
        @(negedge sys_clk);
        n_tests++;
        if (t_if.grant_vld !== 1'b1 || t_if.grant_src !== 2'd1) begin
            n_fail++;
            $display("FAIL to_next: vld=%b src=%0d, required 1/1", t_if.grant_vld, t_if.grant_src);
        end
        t_if.err_clr = 1'b1;
        @(negedge sys_clk);
        t_if.err_clr = 1'b0;
        n_tests++;
        if (t_if.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clr: to=%b after err_clr, required 0", t_if.timeout_err);
        end
        repeat (14) @(negedge sys_clk);
        t_if.rd_done = 1'b1;
        @(negedge sys_clk);
        t_if.rd_done = 1'b0;
        n_tests++;
        if (t_if.grant_vld !== 1'b0 || t_if.timeout_err !== 1'b0
            || t_if.pending_cnt[8 +: 8] !== 8'd0) begin
            n_fail++;
            $display("FAIL to_race: vld=%b to=%b bb_cnt=%0d, required 0/0/0",
                     t_if.grant_vld, t_if.timeout_err, t_if.pending_cnt[8 +: 8]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (4) begin
            s_if.src_frame_done = 4'b0001;
            @(negedge sys_clk);
        end
        s_if.src_frame_done = 4'b0000;
        n_tests++;
        if (s_if.pending_cnt[1:0] !== 2'd3 || s_if.ovf_err !== 4'b0001) begin
            n_fail++;
            $display("FAIL sat_hold: cnt=%0d ovf=%b, required 3/0001",
                     s_if.pending_cnt[1:0], s_if.ovf_err);
        end
        s_if.err_clr = 1'b1;
        @(negedge sys_clk);
        s_if.err_clr = 1'b0;
        n_tests++;
        if (s_if.ovf_err !== 4'b0000 || s_if.pending_cnt[1:0] !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_clr: ovf=%b cnt=%0d, required 0000/3",
                     s_if.ovf_err, s_if.pending_cnt[1:0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        m_if.src_frame_done = 4'b0010;
        @(negedge sys_clk);
        m_if.src_frame_done = 4'b0000;
        wait_grant(ok);
        @(negedge sys_clk);
        m_if.src_frame_done = 4'b0010;
        m_if.rd_done        = 1'b1;
        @(negedge sys_clk);
        m_if.src_frame_done = 4'b0000;
        m_if.rd_done        = 1'b0;
        n_tests++;
        if (!ok || m_if.grant_vld !== 1'b0 || m_if.pending_cnt[8 +: 8] !== 8'd1) begin
            n_fail++;
            $display("FAIL same_edge: ok=%b vld=%b bb_cnt=%0d, required 1/0/1",
                     ok, m_if.grant_vld, m_if.pending_cnt[8 +: 8]);
        end
        @(negedge sys_clk);
        n_tests++;
        if (m_if.grant_vld !== 1'b1 || m_if.grant_src !== 2'd1) begin
            n_fail++;
            $display("FAIL regrant: vld=%b src=%0d, required 1/1", m_if.grant_vld, m_if.grant_src);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_if.grant_vld, m_if.grant_src, m_if.grant_onehot, m_if.ovf_err, m_if.timeout_err}
            !== 12'd0 || m_if.pending_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: vld=%b src=%0d oh=%b pend=%h, all 0 required",
                     m_if.grant_vld, m_if.grant_src, m_if.grant_onehot, m_if.pending_cnt);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_wrr_order();
        test_ctrl_preempt();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdl_frame_scheduler.md
# sdl_frame_scheduler

Downlink SDL frame scheduler. It counts complete frames buffered per source (BSN, BB, circuit, ctrl) and decides which source the SDL frame reader drains next. Ctrl frames get strict priority; BSN/BB/circuit share the link by weighted round-robin. It sits between the four per-source frame buffers and the SDL read/format stage. It issues one grant per frame and holds it until the reader reports the frame consumed, or until a watchdog aborts the frame.

## Interface

Parameters:
- `W_BSN`, 4: frames per round for source 0 (BSN); legal range 1..15.
- `W_BB`, 2: frames per round for source 1 (BB); legal range 1..15.
- `W_CIRCUIT`, 1: frames per round for source 2 (circuit); legal range 1..15.
- `CNT_W`, 8: width of each pending-frame counter.
- `TIMEOUT`, 4096: maximum cycles a grant may stay open; legal range ≥ 2.

Ports (source index = data type code: 0 BSN, 1 BB, 2 circuit, 3 ctrl):
- `sys_clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `src_frame_done` in 4: one-cycle pulse per bit; a complete frame has been written into that source's buffer.
- `rd_done` in 1: one-cycle pulse from the reader; the granted frame has been fully read.
- `err_clr` in 1: pulse; clears the sticky error bits.
- `grant_vld` out 1: a grant is open.
- `grant_src` out 2: index of the granted source; valid while `grant_vld`=1.
- `grant_onehot` out 4: one-hot form of `grant_src`; all zeros when no grant is open.
- `pending_cnt` out 4*CNT_W: per-source pending-frame counts; source i occupies bits [i*CNT_W +: CNT_W].
- `ovf_err` out 4: sticky; a source's counter was already saturated when a frame arrived.
- `timeout_err` out 1: sticky; a grant was aborted by the watchdog.

## Operation

- Reset values: all outputs 0; state IDLE; credits loaded to the weights; `rr_ptr`=0; wait counter 0.
- Pending counters:
  - `src_frame_done[i]` adds 1 to counter i.
  - Closing a grant on source i, by `rd_done` or by timeout, subtracts 1 from counter i.
  - If both happen to the same counter in the same cycle, the net change is zero.
  - At the maximum value (2^CNT_W−1) an increment is dropped, the counter holds, and `ovf_err[i]` is set.
  - A counter never goes below 0.
- States:
  - IDLE: `grant_vld`=0. If any counter is nonzero, register the winner, assert `grant_vld` and go to GRANT; otherwise stay in IDLE.
  - GRANT: grant outputs are held stable.
    - `rd_done`=1: drop the grant, decrement the granted counter, go to IDLE.
    - Otherwise the wait counter increments. When it reaches TIMEOUT−1, drop the grant, decrement the granted counter (the frame is treated as discarded), set `timeout_err`, go to IDLE.
    - If `rd_done` and the timeout fall on the same cycle, `rd_done` wins and `timeout_err` is not set.
- Arbitration, evaluated in IDLE:
  - If counter 3 is nonzero, grant ctrl. Ctrl grants do not touch credits or `rr_ptr`.
  - Otherwise, eligible sources are those with counter > 0 and credit > 0.
    - Search from `rr_ptr` in order ptr, ptr+1, ptr+2 (mod 3) and grant the first eligible source.
    - If sources are requesting but none is eligible, reload all three credits to their weights and search again in the same cycle.
  - After a grant to source s, credit[s] decreases by 1.
    - If credit[s] becomes 0, `rr_ptr` moves to (s+1) mod 3.
    - Otherwise `rr_ptr` stays at s, so a source can burst up to its weight.
- `rd_done` outside GRANT is ignored.
- `err_clr` clears `ovf_err` and `timeout_err`. If a new error event occurs in the same cycle, the set wins.

## Timing

- Latency: `src_frame_done` sampled at edge k → counter updated after edge k → grant decided at edge k+1 → `grant_vld`=1 in cycle k+1 (two edges from the pulse).
- `rd_done` at edge m → `grant_vld`=0 after edge m. The next grant appears no earlier than after edge m+1, so there is always at least one idle cycle between grants.
- `grant_src` and `grant_onehot` change only on the edge where `grant_vld` rises.
- The timeout abort happens on the TIMEOUT-th edge after `grant_vld` rose.
- Reset asserted mid-grant: every output drops immediately to its reset value, and all counters and credits reinitialise.

## Structure

- Shared package `sdl_pkg`: source index constants (0 BSN, 1 BB, 2 circuit, 3 ctrl, matching the data type codes) and the FSM state encoding.
- One natural sub-module, `sdl_wrr_pick`: combinational three-way credit/pointer selection. Its outputs are the winner index, winner valid, and reload flag.
- Pending counters, credits, watchdog and FSM stay in the top module.

## Test plan

- Reset, then a single pulse `src_frame_done`=4'b0010 at cycle 10 → `grant_vld`=1 with `grant_src`=1 in cycle 11; `rd_done` at cycle 20 → `grant_vld`=0 and `pending_cnt` for BB = 0.
- Preload 8 frames each on BSN, BB and circuit, with `rd_done` 3 cycles after every grant → grant order 0,0,0,0,1,1,2, then repeats.
- Ctrl preemption: BSN holds 5 pending frames and a ctrl frame arrives during a BSN grant → the next grant is `grant_src`=3, then BSN resumes with its remaining credit.
- No `rd_done` with TIMEOUT=16 → `grant_vld` falls 16 edges after it rose, `timeout_err`=1, the pending count decrements, and the next source is granted; `rd_done` on that exact edge → `timeout_err` stays 0.
- Saturation with CNT_W=2: 4 BSN frames with no reads → count stays at 3 and `ovf_err`=4'b0001; `err_clr` → `ovf_err`=0.
- A `src_frame_done` pulse on the same edge as `rd_done` for the granted source → that source's count is unchanged; reset asserted mid-grant → all outputs 0 asynchronously.
